phase_sequencer: RTL and testbench

Parametrised run controller for the node-processing pipeline. It starts each enabled processing stage in ascending index order with a one-cycle start pulse and waits for that stage's done. While a stage is active, it routes only that stage's memory address, write data and write enable to the shared node memory. This successor adds an arbitrary stage count, a per-run stage skip mask, a watchdog timeout, abort, and run statistics.

---
 rtl/phase_sequencer.sv | 162 ++++++++++++++++
 tb/tb_phase_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer: runs each enabled processing stage in ascending order with
// a one-cycle start pulse, waits for that stage's done, and routes the active
// stage's memory port to the shared node memory. Supports a per-run skip mask,
// a per-stage watchdog, abort, and a saturating run-length statistic.
module phase_sequencer #(
  parameter int NUM_STAGES = 8,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int TO_W       = 12,
  parameter int STG_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                         clock,
  input  logic                         nrst,
  input  logic                         en,
  input  logic                         abort,
  input  logic [NUM_STAGES-1:0]        stage_mask,
  input  logic [TO_W-1:0]              timeout_limit,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata,
  input  logic [NUM_STAGES-1:0]        stage_wr_en,
  output logic [NUM_STAGES-1:0]        stage_start,
  output logic [ADDR_W-1:0]            address,
  output logic [DATA_W-1:0]            mem_data_in,
  output logic                         wr_en,
  output logic [STG_W-1:0]             cur_stage,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [STG_W-1:0]             err_stage,
  output logic [15:0]                  run_cycles
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic [2:0]            state;
  logic [NUM_STAGES-1:0] mask_q;
  logic [TO_W-1:0]       wdog;
  logic [15:0]           run_cnt;

  logic [STG_W-1:0]      first_idx;
  logic [STG_W-1:0]      next_idx;
  logic                  next_found;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic                  sel_wr;
  logic                  sel_done;

  // Priority encoders: first enabled stage of the incoming mask (used when a
  // run is launched, before mask_q is loaded) and the next enabled stage above
  // the current one in the latched mask.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      if (stage_mask[j]) begin
        first_idx = STG_W'(j);
      end
      if (mask_q[j] && (j > int'(cur_stage))) begin
        next_idx   = STG_W'(j);
        next_found = 1'b1;
      end
    end
  end

  // Select the active stage's memory port and done level.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    sel_done  = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (cur_stage == STG_W'(k)) begin
        sel_addr  = stage_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = stage_wdata[k*DATA_W +: DATA_W];
        sel_wr    = stage_wr_en[k];
        sel_done  = stage_done[k];
      end
    end
  end

  // Output decode: memory port only passes through in WAIT, and an abort
  // cycle never lets a write reach memory.
  always_comb begin
    stage_start = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_start[k] = (state == S_START) && (cur_stage == STG_W'(k));
    end
    address     = (state == S_WAIT) ? sel_addr : '0;
    mem_data_in = (state == S_WAIT) ? sel_wdata : '0;
    wr_en       = (state == S_WAIT) && sel_wr && !abort;
    busy        = (state != S_IDLE) && (state != S_ERROR);
    done        = (state == S_FINISH) && !abort;
    error       = (state == S_ERROR);
  end

  // Run control: state sequencing, watchdog, cycle statistics and error capture.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      mask_q     <= '0;
      cur_stage  <= '0;
      wdog       <= '0;
      run_cnt    <= '0;
      run_cycles <= '0;
      err_stage  <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (en) begin
            mask_q  <= stage_mask;
            run_cnt <= '0;
            if (stage_mask != '0) begin
              cur_stage <= first_idx;
              state     <= S_START;
            end else begin
              state <= S_FINISH;
            end
          end
        end
        S_START: begin
          if (run_cnt != 16'hFFFF) run_cnt <= run_cnt + 16'd1;
          wdog <= '0;
          if (abort) state <= S_IDLE;
          else       state <= S_WAIT;
        end
        S_WAIT: begin
          if (run_cnt != 16'hFFFF) run_cnt <= run_cnt + 16'd1;
          if (abort) begin
            state <= S_IDLE;
          end else if (sel_done) begin
            if (next_found) begin
              cur_stage <= next_idx;
              state     <= S_START;
            end else begin
              state <= S_FINISH;
            end
          end else begin
            wdog <= wdog + TO_W'(1);
            if ((timeout_limit != '0) && (wdog == timeout_limit - TO_W'(1))) begin
              err_stage <= cur_stage;
              state     <= S_ERROR;
            end
          end
        end
        S_FINISH: begin
          if (!abort) begin
            run_cycles <= (run_cnt == 16'hFFFF) ? 16'hFFFF : run_cnt + 16'd1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: scoreboard bench for phase_sequencer. A run-level model
// turns mask/delays/limit into a timed list of start, done and error events;
// a monitor pops them as the DUT shows them and checks the memory mux.
module tb_phase_sequencer;

  localparam int NS = 8;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int TW = 12;
  localparam int SW = 3;

  localparam int EV_START = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic             clock = 1'b0;
  logic             nrst = 1'b1;
  logic             en = 1'b0;
  logic             abort = 1'b0;
  logic [NS-1:0]    stage_mask = '0;
  logic [TW-1:0]    timeout_limit = '0;
  logic [NS-1:0]    stage_done = '0;
  logic [NS*AW-1:0] stage_addr = '0;
  logic [NS*DW-1:0] stage_wdata = '0;
  logic [NS-1:0]    stage_wr_en = '0;
  logic [NS-1:0]    stage_start;
  logic [AW-1:0]    address;
  logic [DW-1:0]    mem_data_in;
  logic             wr_en;
  logic [SW-1:0]    cur_stage;
  logic             busy;
  logic             done;
  logic             error;
  logic [SW-1:0]    err_stage;
  logic [15:0]      run_cycles;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   delay [NS];
  bit   fixed_mode = 1'b0;
  int   last_rc = 0;
  ev_t  sb [$];

  phase_sequencer #(
    .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .TO_W(TW)
  ) dut (
    .clock(clock), .nrst(nrst), .en(en), .abort(abort),
    .stage_mask(stage_mask), .timeout_limit(timeout_limit),
    .stage_done(stage_done), .stage_addr(stage_addr),
    .stage_wdata(stage_wdata), .stage_wr_en(stage_wr_en),
    .stage_start(stage_start), .address(address),
    .mem_data_in(mem_data_in), .wr_en(wr_en), .cur_stage(cur_stage),
    .busy(busy), .done(done), .error(error), .err_stage(err_stage),
    .run_cycles(run_cycles)
  );

  // Free-running clock and a cycle counter used to time-stamp events.
  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Safety net in case anything stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] stalled");
  end

  task automatic check_output(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_start"}, stage_start, 0);
    check_output({tag, "_addr"}, address, 0);
    check_output({tag, "_data"}, mem_data_in, 0);
    check_output({tag, "_wr"}, wr_en, 0);
    check_output({tag, "_cur"}, cur_stage, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_error"}, error, 0);
    check_output({tag, "_errstg"}, err_stage, 0);
    check_output({tag, "_rc"}, run_cycles, 0);
  endtask

  // Pop the next expected event and compare its kind, timing and payload.
  task automatic pop_check(input int kind, input int val, output int exp_val);
    ev_t e;
    exp_val = -1;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL sb_unexpected kind=%0d val=%0d expected=none at cycle %0d", kind, val, cyc);
    end else begin
      total--;
      e = sb.pop_front();
      exp_val = e.val;
      check_output("ev_kind", kind, e.kind);
      check_output("ev_cycle", cyc, e.cyc);
      if (kind != EV_DONE) check_output("ev_stage", val, e.val);
    end
  endtask

  // Stage stubs: each started stage raises done 'delay' cycles after its
  // start pulse (0 = never); idle stages toggle done randomly, which the DUT
  // must ignore. Memory ports carry random traffic unless fixed_mode is set.
  initial begin
    bit [NS-1:0] act;
    int          elapsed [NS];
    logic [NS-1:0] st_s;
    logic [NS-1:0] dn_s;
    logic          ab_s;
    act = '0;
    for (int k = 0; k < NS; k++) elapsed[k] = 0;
    forever begin
      @(negedge clock);
      st_s = stage_start;
      dn_s = stage_done;
      ab_s = abort;
      @(posedge clock);
      #1;
      for (int k = 0; k < NS; k++) begin
        if (!nrst || ab_s) act[k] = 1'b0;
        else if (st_s[k]) begin
          act[k] = 1'b1;
          elapsed[k] = 1;
        end else if (act[k]) begin
          if (dn_s[k]) act[k] = 1'b0;
          else elapsed[k]++;
        end
        stage_done[k] = act[k] ? (delay[k] != 0 && elapsed[k] >= delay[k]) : 1'($urandom);
        if (fixed_mode) begin
          stage_addr[k*AW +: AW]  = (k == 3) ? 11'h0C8 : 11'h5AD;
          stage_wdata[k*DW +: DW] = (k == 3) ? 16'h5999 : 16'hDEAD;
          stage_wr_en[k]          = 1'b1;
        end else begin
          stage_addr[k*AW +: AW]  = AW'($urandom);
          stage_wdata[k*DW +: DW] = DW'($urandom);
          stage_wr_en[k]          = 1'($urandom);
        end
      end
    end
  end

  // Monitor: pops expected events when the DUT shows a start, done or error,
  // checks run_cycles the cycle after done, and checks the memory mux.
  initial begin
    int wait_stage;
    int pending_rc;
    int ev_val;
    int idx;
    bit err_prev;
    wait_stage = -1;
    pending_rc = -1;
    err_prev   = 1'b0;
    forever begin
      @(negedge clock);
      if (!nrst) begin
        wait_stage = -1;
        pending_rc = -1;
        err_prev   = 1'b0;
        continue;
      end
      if (pending_rc >= 0) begin
        check_output("run_cycles", run_cycles, pending_rc);
        pending_rc = -1;
      end
      if (stage_start != '0) begin
        idx = 0;
        for (int k = 0; k < NS; k++) if (stage_start[k]) idx = k;
        check_output("start_onehot", $countones(stage_start), 1);
        pop_check(EV_START, idx, ev_val);
        wait_stage = idx;
      end
      if (done) begin
        pop_check(EV_DONE, 0, ev_val);
        pending_rc = ev_val;
        wait_stage = -1;
      end
      if (error && !err_prev) begin
        pop_check(EV_ERR, int'(err_stage), ev_val);
        wait_stage = -1;
      end
      err_prev = error;
      if (busy && stage_start == '0 && !done && wait_stage >= 0) begin
        check_output("mux_addr", address, stage_addr[wait_stage*AW +: AW]);
        check_output("mux_data", mem_data_in, stage_wdata[wait_stage*DW +: DW]);
        check_output("mux_wr", wr_en, abort ? 1'b0 : stage_wr_en[wait_stage]);
      end else begin
        check_output("quiet_addr", address, 0);
        check_output("quiet_data", mem_data_in, 0);
        check_output("quiet_wr", wr_en, 0);
      end
      if (fixed_mode && wr_en) begin
        check_output("t3_addr", address, 11'h0C8);
        check_output("t3_data", mem_data_in, 16'h5999);
      end
      if (abort) wait_stage = -1;
    end
  end

  // Launch one run. The reference model walks the enabled stages in order:
  // each costs one start cycle plus 'delay' wait cycles, unless the watchdog
  // (limit wait cycles) fires first. cut_kind 1 aborts / 2 resets during the
  // cut_wait-th wait cycle of cut_stage.
  task automatic apply_stimulus(input logic [NS-1:0] mask, input int limit,
                                input int cut_kind, input int cut_stage, input int cut_wait);
    int  n, t, end_c, cut_c, w;
    bit  ended;
    @(posedge clock);
    #1;
    n = cyc;
    t = n + 1;
    ended = 1'b0;
    cut_c = -1;
    end_c = 0;
    for (int k = 0; k < NS; k++) begin
      if (mask[k] && !ended) begin
        sb.push_back('{EV_START, k, t});
        w = delay[k];
        if (cut_kind != 0 && k == cut_stage) begin
          cut_c = t + cut_wait;
          end_c = cut_c;
          ended = 1'b1;
        end else if (w == 0 || (limit != 0 && w > limit)) begin
          sb.push_back('{EV_ERR, k, t + 1 + limit});
          end_c = t + 1 + limit;
          ended = 1'b1;
        end else begin
          t = t + 1 + w;
        end
      end
    end
    if (!ended) begin
      sb.push_back('{EV_DONE, t - n, t});
      end_c = t;
      last_rc = t - n;
    end
    stage_mask    = mask;
    timeout_limit = TW'(limit);
    en            = 1'b1;
    @(posedge clock);
    #1;
    en         = 1'b0;
    stage_mask = NS'($urandom);
    while (cyc < end_c + 1) begin
      if (cut_kind == 1) abort = (cyc == cut_c);
      if (cut_kind == 2 && cyc == cut_c) begin
        #2;
        nrst = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        sb.delete();
        last_rc = 0;
        repeat (2) @(posedge clock);
        #3;
        nrst = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    abort = 1'b0;
    check_output("sb_drained", sb.size(), 0);
  endtask

  task automatic set_delays(input int d);
    for (int k = 0; k < NS; k++) delay[k] = d;
  endtask

  initial begin
    int lim;
    set_delays(1);
    #1;
    nrst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    #2;
    nrst = 1'b1;

    $display("[TB] full run, all stages");
    set_delays(3);
    apply_stimulus(8'hFF, 0, 0, 0, 0);
    check_output("t1_run_cycles", run_cycles, 33);

    $display("[TB] skip mask");
    set_delays(1);
    apply_stimulus(8'b1010_0101, 0, 0, 0, 0);
    check_output("t2_run_cycles", run_cycles, 9);

    $display("[TB] write path through stage 3");
    fixed_mode = 1'b1;
    set_delays(2);
    apply_stimulus(8'b0000_1000, 0, 0, 0, 0);
    fixed_mode = 1'b0;

    $display("[TB] watchdog timeout on stage 4");
    set_delays(2);
    delay[4] = 0;
    apply_stimulus(8'b0001_0001, 5, 0, 0, 0);
    check_output("t4_error", error, 1);
    check_output("t4_err_stage", err_stage, 4);
    check_output("t4_busy", busy, 0);
    check_output("t4_wr", wr_en, 0);
    delay[4] = 2;
    apply_stimulus(8'b0001_0110, 5, 0, 0, 0);
    check_output("t4_error_cleared", error, 0);
    check_output("t4_err_stage_hold", err_stage, 4);

    $display("[TB] empty mask and abort");
    apply_stimulus(8'h00, 0, 0, 0, 0);
    check_output("t5_run_cycles", run_cycles, 1);
    set_delays(4);
    apply_stimulus(8'hFF, 0, 1, 2, 2);
    check_output("t5_abort_rc", run_cycles, 1);
    check_output("t5_abort_busy", busy, 0);

    $display("[TB] reset mid-run");
    apply_stimulus(8'hFF, 0, 2, 6, 2);
    check_output("t6_busy", busy, 0);
    set_delays(2);
    apply_stimulus(8'b0100_0100, 0, 0, 0, 0);
    check_output("t6_run_cycles", run_cycles, 7);

    $display("[TB] randomized runs");
    for (int r = 0; r < 25; r++) begin
      lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
      for (int k = 0; k < NS; k++) begin
        delay[k] = $urandom_range(1, 6);
        if (lim != 0 && $urandom_range(0, 9) == 0) delay[k] = 0;
      end
      apply_stimulus(NS'($urandom), lim, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
